// File: rtl/nasti_fifo_buf.sv
// Per-channel FIFO buffering between a NASTI (AXI4) slave port s and master port m.
// Each channel has its own depth (0 = wire-through); stall blocks new AW/AR while the buffers drain.

module nasti_fifo_buf_chan #(
  parameter int W  = 8,
  parameter int D  = 2,
  parameter int LW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] level,
  output logic          empty
);

  if (D == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rstn};
    assign out_valid     = in_valid;
    assign in_ready      = out_ready;
    assign out_data      = in_data;
    assign level         = '0;
    assign empty         = 1'b1;
  end else begin : g_fifo
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    // in_ready looks only at the count, so a full FIFO cannot refill in its pop cycle.
    assign in_ready  = (cnt_q != LW'(D));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (push) wp_d = (wp_q == PW'(D - 1)) ? '0 : wp_q + PW'(1);
      if (pop)  rp_d = (rp_q == PW'(D - 1)) ? '0 : rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + LW'(1);
      else if (pop && !push) cnt_d = cnt_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end

    // Payload storage is deliberately unreset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= in_data;
    end

    assign out_data = mem_q[rp_q];
    assign level    = cnt_q;
    assign empty    = (cnt_q == '0);
  end

endmodule

module nasti_fifo_buf #(
  parameter int AW_DEPTH   = 2,
  parameter int AR_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int R_DEPTH    = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  // slave port s: AW
  input  logic                    s_aw_valid,
  output logic                    s_aw_ready,
  input  logic [ID_WIDTH-1:0]     s_aw_id,
  input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
  input  logic [7:0]              s_aw_len,
  input  logic [2:0]              s_aw_size,
  input  logic [1:0]              s_aw_burst,
  input  logic                    s_aw_lock,
  input  logic [3:0]              s_aw_cache,
  input  logic [2:0]              s_aw_prot,
  input  logic [3:0]              s_aw_qos,
  input  logic [3:0]              s_aw_region,
  input  logic [USER_WIDTH-1:0]   s_aw_user,
  // slave port s: AR
  input  logic                    s_ar_valid,
  output logic                    s_ar_ready,
  input  logic [ID_WIDTH-1:0]     s_ar_id,
  input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [7:0]              s_ar_len,
  input  logic [2:0]              s_ar_size,
  input  logic [1:0]              s_ar_burst,
  input  logic                    s_ar_lock,
  input  logic [3:0]              s_ar_cache,
  input  logic [2:0]              s_ar_prot,
  input  logic [3:0]              s_ar_qos,
  input  logic [3:0]              s_ar_region,
  input  logic [USER_WIDTH-1:0]   s_ar_user,
  // slave port s: W
  input  logic                    s_w_valid,
  output logic                    s_w_ready,
  input  logic [DATA_WIDTH-1:0]   s_w_data,
  input  logic [DATA_WIDTH/8-1:0] s_w_strb,
  input  logic                    s_w_last,
  input  logic [USER_WIDTH-1:0]   s_w_user,
  // slave port s: B
  output logic                    s_b_valid,
  input  logic                    s_b_ready,
  output logic [ID_WIDTH-1:0]     s_b_id,
  output logic [1:0]              s_b_resp,
  output logic [USER_WIDTH-1:0]   s_b_user,
  // slave port s: R
  output logic                    s_r_valid,
  input  logic                    s_r_ready,
  output logic [ID_WIDTH-1:0]     s_r_id,
  output logic [DATA_WIDTH-1:0]   s_r_data,
  output logic [1:0]              s_r_resp,
  output logic                    s_r_last,
  output logic [USER_WIDTH-1:0]   s_r_user,
  // master port m: AW
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [ID_WIDTH-1:0]     m_aw_id,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [7:0]              m_aw_len,
  output logic [2:0]              m_aw_size,
  output logic [1:0]              m_aw_burst,
  output logic                    m_aw_lock,
  output logic [3:0]              m_aw_cache,
  output logic [2:0]              m_aw_prot,
  output logic [3:0]              m_aw_qos,
  output logic [3:0]              m_aw_region,
  output logic [USER_WIDTH-1:0]   m_aw_user,
  // master port m: AR
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  output logic [ID_WIDTH-1:0]     m_ar_id,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [7:0]              m_ar_len,
  output logic [2:0]              m_ar_size,
  output logic [1:0]              m_ar_burst,
  output logic                    m_ar_lock,
  output logic [3:0]              m_ar_cache,
  output logic [2:0]              m_ar_prot,
  output logic [3:0]              m_ar_qos,
  output logic [3:0]              m_ar_region,
  output logic [USER_WIDTH-1:0]   m_ar_user,
  // master port m: W
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_last,
  output logic [USER_WIDTH-1:0]   m_w_user,
  // master port m: B
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  input  logic [ID_WIDTH-1:0]     m_b_id,
  input  logic [1:0]              m_b_resp,
  input  logic [USER_WIDTH-1:0]   m_b_user,
  // master port m: R
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  input  logic [ID_WIDTH-1:0]     m_r_id,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_last,
  input  logic [USER_WIDTH-1:0]   m_r_user,
  // control and status
  input  logic                    stall,
  output logic                    idle,
  output logic [((AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1))-1:0] aw_level,
  output logic [((AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1))-1:0] ar_level,
  output logic [((W_DEPTH  == 0) ? 1 : $clog2(W_DEPTH  + 1))-1:0] w_level,
  output logic [((B_DEPTH  == 0) ? 1 : $clog2(B_DEPTH  + 1))-1:0] b_level,
  output logic [((R_DEPTH  == 0) ? 1 : $clog2(R_DEPTH  + 1))-1:0] r_level
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AX_W   = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 29;
  localparam int WB_W   = DATA_WIDTH + STRB_W + 1 + USER_WIDTH;
  localparam int BB_W   = ID_WIDTH + 2 + USER_WIDTH;
  localparam int RB_W   = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;
  localparam int AW_LW  = (AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1);
  localparam int AR_LW  = (AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1);
  localparam int W_LW   = (W_DEPTH  == 0) ? 1 : $clog2(W_DEPTH  + 1);
  localparam int B_LW   = (B_DEPTH  == 0) ? 1 : $clog2(B_DEPTH  + 1);
  localparam int R_LW   = (R_DEPTH  == 0) ? 1 : $clog2(R_DEPTH  + 1);

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [WB_W-1:0] w_in, w_out;
  logic [BB_W-1:0] b_in, b_out;
  logic [RB_W-1:0] r_in, r_out;
  logic            aw_in_valid, aw_in_ready, ar_in_valid, ar_in_ready;
  logic            aw_empty, ar_empty, w_empty, b_empty, r_empty;

  assign aw_in = {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                  s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user};
  assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
          m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user} = aw_out;
  assign ar_in = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                  s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user};
  assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
          m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user} = ar_out;
  assign w_in = {s_w_data, s_w_strb, s_w_last, s_w_user};
  assign {m_w_data, m_w_strb, m_w_last, m_w_user} = w_out;
  assign b_in = {m_b_id, m_b_resp, m_b_user};
  assign {s_b_id, s_b_resp, s_b_user} = b_out;
  assign r_in = {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
  assign {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user} = r_out;

  // Gating both valid and ready on the s side also keeps a bypassed AW/AR from leaking to m.
  assign aw_in_valid = s_aw_valid && !stall;
  assign s_aw_ready  = aw_in_ready && !stall;
  assign ar_in_valid = s_ar_valid && !stall;
  assign s_ar_ready  = ar_in_ready && !stall;

  nasti_fifo_buf_chan #(.W(AX_W), .D(AW_DEPTH), .LW(AW_LW)) u_aw (
    .clk(clk), .rstn(rstn),
    .in_valid(aw_in_valid), .in_ready(aw_in_ready), .in_data(aw_in),
    .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_data(aw_out),
    .level(aw_level), .empty(aw_empty)
  );

  nasti_fifo_buf_chan #(.W(AX_W), .D(AR_DEPTH), .LW(AR_LW)) u_ar (
    .clk(clk), .rstn(rstn),
    .in_valid(ar_in_valid), .in_ready(ar_in_ready), .in_data(ar_in),
    .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_data(ar_out),
    .level(ar_level), .empty(ar_empty)
  );

  nasti_fifo_buf_chan #(.W(WB_W), .D(W_DEPTH), .LW(W_LW)) u_w (
    .clk(clk), .rstn(rstn),
    .in_valid(s_w_valid), .in_ready(s_w_ready), .in_data(w_in),
    .out_valid(m_w_valid), .out_ready(m_w_ready), .out_data(w_out),
    .level(w_level), .empty(w_empty)
  );

  nasti_fifo_buf_chan #(.W(BB_W), .D(B_DEPTH), .LW(B_LW)) u_b (
    .clk(clk), .rstn(rstn),
    .in_valid(m_b_valid), .in_ready(m_b_ready), .in_data(b_in),
    .out_valid(s_b_valid), .out_ready(s_b_ready), .out_data(b_out),
    .level(b_level), .empty(b_empty)
  );

  nasti_fifo_buf_chan #(.W(RB_W), .D(R_DEPTH), .LW(R_LW)) u_r (
    .clk(clk), .rstn(rstn),
    .in_valid(m_r_valid), .in_ready(m_r_ready), .in_data(r_in),
    .out_valid(s_r_valid), .out_ready(s_r_ready), .out_data(r_out),
    .level(r_level), .empty(r_empty)
  );

  // Bypassed channels report empty permanently, so they never hold idle low.
  assign idle = aw_empty && ar_empty && w_empty && b_empty && r_empty;

endmodule

// File: tb/tb_nasti_fifo_buf.sv
// Directed bench for nasti_fifo_buf: AW depth 3, AR/W/B depth 2, R bypassed.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.

module tb_nasti_fifo_buf;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       s_aw_valid, s_aw_ready, s_aw_id, s_aw_lock, s_aw_user;
  logic [7:0] s_aw_addr, s_aw_len;
  logic [2:0] s_aw_size, s_aw_prot;
  logic [1:0] s_aw_burst;
  logic [3:0] s_aw_cache, s_aw_qos, s_aw_region;
  logic       s_ar_valid, s_ar_ready, s_ar_id, s_ar_lock, s_ar_user;
  logic [7:0] s_ar_addr, s_ar_len;
  logic [2:0] s_ar_size, s_ar_prot;
  logic [1:0] s_ar_burst;
  logic [3:0] s_ar_cache, s_ar_qos, s_ar_region;
  logic       s_w_valid, s_w_ready, s_w_strb, s_w_last, s_w_user;
  logic [7:0] s_w_data;
  logic       s_b_valid, s_b_ready, s_b_id, s_b_user;
  logic [1:0] s_b_resp;
  logic       s_r_valid, s_r_ready, s_r_id, s_r_last, s_r_user;
  logic [7:0] s_r_data;
  logic [1:0] s_r_resp;
  logic       m_aw_valid, m_aw_ready, m_aw_id, m_aw_lock, m_aw_user;
  logic [7:0] m_aw_addr, m_aw_len;
  logic [2:0] m_aw_size, m_aw_prot;
  logic [1:0] m_aw_burst;
  logic [3:0] m_aw_cache, m_aw_qos, m_aw_region;
  logic       m_ar_valid, m_ar_ready, m_ar_id, m_ar_lock, m_ar_user;
  logic [7:0] m_ar_addr, m_ar_len;
  logic [2:0] m_ar_size, m_ar_prot;
  logic [1:0] m_ar_burst;
  logic [3:0] m_ar_cache, m_ar_qos, m_ar_region;
  logic       m_w_valid, m_w_ready, m_w_strb, m_w_last, m_w_user;
  logic [7:0] m_w_data;
  logic       m_b_valid, m_b_ready, m_b_id, m_b_user;
  logic [1:0] m_b_resp;
  logic       m_r_valid, m_r_ready, m_r_id, m_r_last, m_r_user;
  logic [7:0] m_r_data;
  logic [1:0] m_r_resp;
  logic       stall, idle;
  logic [1:0] aw_level, ar_level, w_level, b_level;
  logic       r_level;

  int n_checks = 0;
  int n_errors = 0;

  nasti_fifo_buf #(
    .AW_DEPTH(3), .AR_DEPTH(2), .W_DEPTH(2), .B_DEPTH(2), .R_DEPTH(0),
    .ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
    .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos), .s_aw_region(s_aw_region),
    .s_aw_user(s_aw_user),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
    .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos), .s_ar_region(s_ar_region),
    .s_ar_user(s_ar_user),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last), .s_w_user(s_w_user),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_b_user(s_b_user),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_user(s_r_user),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
    .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos), .m_aw_region(m_aw_region),
    .m_aw_user(m_aw_user),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
    .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_region(m_ar_region),
    .m_ar_user(m_ar_user),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last), .m_w_user(m_w_user),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_b_user(m_b_user),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_user(m_r_user),
    .stall(stall), .idle(idle),
    .aw_level(aw_level), .ar_level(ar_level), .w_level(w_level), .b_level(b_level),
    .r_level(r_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0;
    s_aw_valid = 0; s_aw_id = 0; s_aw_addr = 0; s_aw_len = 0; s_aw_size = 0; s_aw_burst = 0;
    s_aw_lock = 0; s_aw_cache = 0; s_aw_prot = 0; s_aw_qos = 0; s_aw_region = 0; s_aw_user = 0;
    s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_size = 0; s_ar_burst = 0;
    s_ar_lock = 0; s_ar_cache = 0; s_ar_prot = 0; s_ar_qos = 0; s_ar_region = 0; s_ar_user = 0;
    s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0; s_w_user = 0;
    s_b_ready = 0; s_r_ready = 0;
    m_aw_ready = 0; m_ar_ready = 0; m_w_ready = 0;
    m_b_valid = 0; m_b_id = 0; m_b_resp = 0; m_b_user = 0;
    m_r_valid = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0; m_r_user = 0;
    step();
    step();
    rstn = 1'b1;
    settle();

    // reset state
    check("rst_idle", idle, 1);
    check("rst_levels", {aw_level, ar_level, w_level, b_level, 1'b0, r_level}, 0);
    check("rst_m_valids", {m_aw_valid, m_ar_valid, m_w_valid, s_b_valid}, 0);
    check("rst_s_readies", {s_aw_ready, s_ar_ready, s_w_ready, m_b_ready}, 4'hf);

    // 1: fill the AW FIFO with the master stalled
    for (int i = 1; i <= 3; i++) begin
      s_aw_valid = 1; s_aw_addr = 8'(i * 16); s_aw_len = 8'(i); s_aw_id = 1'(i);
      settle();
      check("t1_aw_ready_pre", s_aw_ready, 1);
      check("t1_level_pre", aw_level, 32'(i - 1));
      step();
    end
    s_aw_addr = 8'h40; s_aw_len = 8'h4;
    settle();
    check("t1_full_ready", s_aw_ready, 0);
    check("t1_full_level", aw_level, 3);
    check("t1_idle", idle, 0);
    check("t1_head_addr", m_aw_addr, 8'h10);
    step();
    check("t1_held_level", aw_level, 3);

    // 2: drain in order; full FIFO does not accept in its pop cycle
    s_aw_valid = 0; m_aw_ready = 1;
    settle();
    check("t2_ready_at_pop", s_aw_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      check("t2_m_valid", m_aw_valid, 1);
      check("t2_m_addr", m_aw_addr, 32'(i * 16));
      check("t2_m_len", m_aw_len, 32'(i));
      check("t2_m_id", m_aw_id, 32'(i % 2));
      step();
      settle();
      check("t2_ready_after", s_aw_ready, 1);
      check("t2_level", aw_level, 32'(3 - i));
    end
    check("t2_m_valid_end", m_aw_valid, 0);
    check("t2_idle_end", idle, 1);
    m_aw_ready = 0;

    // 3: 8-beat W burst streamed through the 2-deep FIFO
    m_w_ready = 1;
    for (int k = 0; k <= 8; k++) begin
      s_w_valid = (k < 8); s_w_data = 8'(8'h80 + k); s_w_strb = 1; s_w_last = (k == 7);
      settle();
      check("t3_s_ready", s_w_ready, 1);
      check("t3_m_valid", m_w_valid, (k > 0) ? 1 : 0);
      check("t3_level", w_level, (k > 0) ? 1 : 0);
      if (k > 0) begin
        check("t3_m_data", m_w_data, 32'(8'h80 + k - 1));
        check("t3_m_last", m_w_last, (k == 8) ? 1 : 0);
      end
      step();
    end
    s_w_valid = 0; s_w_last = 0;
    settle();
    check("t3_level_end", w_level, 0);
    m_w_ready = 0;

    // 4: R bypass is purely combinational
    m_r_valid = 1; m_r_id = 1; m_r_data = 8'ha5; m_r_resp = 2'b01; m_r_last = 1; m_r_user = 1;
    s_r_ready = 0;
    settle();
    check("t4_s_valid", s_r_valid, 1);
    check("t4_s_payload", {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user}, {1'b1, 8'ha5, 2'b01, 1'b1, 1'b1});
    check("t4_m_ready_lo", m_r_ready, 0);
    s_r_ready = 1;
    settle();
    check("t4_m_ready_hi", m_r_ready, 1);
    check("t4_level", r_level, 0);
    check("t4_idle", idle, 1);
    step();
    m_r_valid = 0; s_r_ready = 0;

    // B channel buffered one cycle
    m_b_valid = 1; m_b_id = 1; m_b_resp = 2'b10; m_b_user = 1;
    settle();
    check("tb_s_valid_pre", s_b_valid, 0);
    step();
    m_b_valid = 0;
    settle();
    check("tb_s_valid", s_b_valid, 1);
    check("tb_payload", {s_b_id, s_b_resp, s_b_user}, 4'b1101);
    check("tb_level", b_level, 1);
    check("tb_idle", idle, 0);
    s_b_ready = 1;
    step();
    s_b_ready = 0;
    settle();
    check("tb_level_end", b_level, 0);

    // 5: stall with two buffered AR entries and a pending AR
    for (int i = 0; i < 2; i++) begin
      s_ar_valid = 1; s_ar_addr = 8'(8'h50 + 16 * i);
      step();
    end
    s_ar_addr = 8'h70; stall = 1;
    settle();
    check("t5_level_full", ar_level, 2);
    check("t5_ready_stall", s_ar_ready, 0);
    m_ar_ready = 1;
    settle();
    check("t5_m_addr0", m_ar_addr, 8'h50);
    step();
    check("t5_m_addr1", m_ar_addr, 8'h60);
    check("t5_level1", ar_level, 1);
    check("t5_ready_notfull", s_ar_ready, 0);
    step();
    check("t5_level0", ar_level, 0);
    check("t5_m_valid0", m_ar_valid, 0);
    check("t5_idle", idle, 1);
    m_ar_ready = 0; stall = 0;
    settle();
    check("t5_ready_unstall", s_ar_ready, 1);
    step();
    s_ar_valid = 0;
    settle();
    check("t5_level_pend", ar_level, 1);
    check("t5_m_addr_pend", m_ar_addr, 8'h70);
    m_ar_ready = 1;
    step();
    m_ar_ready = 0;
    check("t5_level_done", ar_level, 0);

    // 6: asynchronous reset with two W beats buffered
    for (int i = 0; i < 2; i++) begin
      s_w_valid = 1; s_w_data = 8'(8'hc1 + i);
      step();
    end
    s_w_valid = 0;
    settle();
    check("t6_level_pre", w_level, 2);
    check("t6_m_valid_pre", m_w_valid, 1);
    rstn = 0;
    settle();
    check("t6_m_valid_rst", m_w_valid, 0);
    check("t6_level_rst", w_level, 0);
    check("t6_idle_rst", idle, 1);
    check("t6_ready_rst", s_w_ready, 1);
    @(posedge clk);
    #2;
    rstn = 1;
    m_w_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_stale", m_w_valid, 0);
      check("t6_level_post", w_level, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
